bit_reverse_ctrl: RTL and testbench
===================================

Name: bit_reverse_ctrl

Overview:
- Sequencer for the bit-reverse reorder stage behind the R22SDF pipeline.
- Drives an external true dual-port sync BRAM of 2*N words (DWIDTH x 2^(LOG2N+1)) as a ping-pong buffer.
- Port 0 writes incoming FFT frames in natural order; port 1 reads completed frames in bit-reversed order.
- Valid/ready streaming on both sides; back-pressure propagates input-ward when both banks are occupied.

Parameters:
- DWIDTH, 32, sample width (packed re/im); must match BRAM DWIDTH.
- LOG2N, 6, log2 of frame length N; BRAM AWIDTH = LOG2N+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller accepts sample.
- in_data  in  DWIDTH  input sample, natural order.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts sample.
- out_data  out  DWIDTH  output sample, bit-reversed order (= mem_q1).
- out_last  out  1  last sample of output frame.
- mem_addr0  out  LOG2N+1  BRAM port-0 address {wr_bank, wr_cnt}.
- mem_ce0  out  1  port-0 enable.
- mem_we0  out  1  port-0 write enable.
- mem_d0  out  DWIDTH  port-0 write data.
- mem_addr1  out  LOG2N+1  BRAM port-1 address {rd_bank, bitrev(rd_cnt)}.
- mem_ce1  out  1  port-1 enable.
- mem_we1  out  1  port-1 write enable, tied 0.
- mem_d1  out  DWIDTH  tied 0.
- mem_q1  in  DWIDTH  port-1 read data, 1-cycle latency, holds when ce1=0.

Behaviour:
- Clock/reset: single clock clk; rst is synchronous, active-high.
- Reset: wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, full[1:0]=0, out_valid=0, out_last=0.
- Reset mid-frame discards all partial and complete frames. Any stale mem_q1 is ignored.
- Writer:
  - in_ready = !full[wr_bank] (combinational).
  - On in_valid&in_ready: mem_ce0=mem_we0=1, mem_addr0={wr_bank,wr_cnt}, mem_d0=in_data, wr_cnt++.
  - When wr_cnt==N-1 is accepted: full[wr_bank]<=1, wr_bank toggles, wr_cnt wraps to 0.
  - mem_ce0/mem_we0 are 0 otherwise.
- Reader:
  - States R_IDLE and R_READ.
  - R_IDLE -> R_READ when full[rd_bank]=1.
  - Issue condition: R_READ & (!out_valid | out_ready). On issue: mem_ce1=1, mem_addr1={rd_bank, bitrev(rd_cnt)}, rd_cnt++.
  - out_valid<=1 on the edge after an issue.
  - out_valid<=0 when out_ready is accepted with no new issue.
  - out_last is registered alongside out_valid and is 1 for the beat read at rd_cnt==N-1.
  - On issuing rd_cnt==N-1: full[rd_bank]<=0, rd_bank toggles, rd_cnt wraps, state -> R_IDLE (or stays R_READ if the other bank is full; back-to-back frames have no bubble).
- Stalls: while out_valid&!out_ready, mem_ce1=0. mem_q1 holds, so out_data stays stable (AXI-style hold).
- Bitrev: rd address bit i = rd_cnt bit (LOG2N-1-i).
- Latency: first out_valid is asserted 2 cycles after the cycle in which the last input beat of a frame is accepted. With out_ready=1 throughout, throughput is 1 sample/cycle sustained and in_ready never drops.
- Simultaneous events:
  - Writer setting full on one bank and reader clearing full on the other bank in the same edge: both take effect.
  - Writer blocked on bank X while reader clears full[X] in cycle c: in_ready rises in cycle c+1.
  - Read of the last address and a later write to the same address never overlap: the read completes on the clearing edge.
- Full/empty:
  - Both banks full -> in_ready=0 until the reader issues the last read of the older bank.
  - No bank full -> reader idle, out_valid falls after the final beat drains.

Optional Feature:
- Macro BITREV_CTRL_STATS_EN.
- When defined, adds two outputs:
  - frames_out [15:0]: counts accepted out_last beats, wraps at 2^16.
  - in_stall_cycles [15:0]: counts cycles with in_valid&!in_ready, saturates at 16'hFFFF.
  - Both clear on rst.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- LOG2N=3, input 0..7 back-to-back, out_ready=1 -> outputs 0,4,2,6,1,5,3,7; out_last only on 7; first out_valid 2 cycles after input 7 is accepted.
- Three consecutive frames 0..23 continuous, out_ready=1 -> in_ready stays 1 throughout; outputs are 24 beats with no bubbles between frames; mem_addr1 bank bit alternates 0,1,0.
- out_ready=0 held, 24 samples offered -> in_ready drops after sample 15 is accepted; release out_ready -> in_ready returns the cycle after output beat 7's read issues; no samples lost.
- Random out_ready toggling -> out_data/out_last stable while out_valid&!out_ready; sequence matches the golden bitrev model.
- rst pulsed after 5 samples of a frame -> out_valid=0, in_ready=1 next cycle; next full frame 8..15 outputs 8,12,10,14,9,13,11,15.
- BITREV_CTRL_STATS_EN, scenario 3 -> frames_out=3 at end; in_stall_cycles equals the count of cycles offered-but-blocked (checked against the bench counter).

Source files
------------

// File: rtl/bit_reverse_ctrl.sv
// rtl/bit_reverse_ctrl.sv - ping-pong bit-reverse reorder sequencer for an external dual-port BRAM
//
// Purpose:
//   Takes FFT frames of N = 2^LOG2N samples in natural order. Each frame is written
//   into one half (bank) of an external true dual-port BRAM of 2*N words. A full
//   bank is read back in bit-reversed order. The two banks work as a ping-pong
//   buffer, so one frame can be written while the other frame is read.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready/in_data    natural-order input stream
//   out_valid/out_ready/out_data output stream in bit-reversed order
//   out_last                     marks the last beat of an output frame
//   mem_addr0/ce0/we0/d0         BRAM port 0, write side {wr_bank, wr_cnt}
//   mem_addr1/ce1/we1/d1/q1      BRAM port 1, read side {rd_bank, bitrev(rd_cnt)}
//                                q1 has 1-cycle latency and holds while ce1=0
//
// Optional:
//   BITREV_CTRL_STATS_EN adds the outputs frames_out (wrapping count of accepted
//   out_last beats) and in_stall_cycles (saturating count of in_valid & !in_ready).

module bit_reverse_ctrl #(
  parameter int DWIDTH = 32,
  parameter int LOG2N  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
`ifdef BITREV_CTRL_STATS_EN
  output logic [15:0]       frames_out,
  output logic [15:0]       in_stall_cycles,
`endif
  output logic [LOG2N:0]    mem_addr0,
  output logic              mem_ce0,
  output logic              mem_we0,
  output logic [DWIDTH-1:0] mem_d0,
  output logic [LOG2N:0]    mem_addr1,
  output logic              mem_ce1,
  output logic              mem_we1,
  output logic [DWIDTH-1:0] mem_d1,
  input  logic [DWIDTH-1:0] mem_q1
);

  localparam logic [LOG2N-1:0] CNT_MAX = '1;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_t;

  rd_state_t        r_state;
  rd_state_t        w_state_nxt;
  logic [1:0]       r_full;
  logic [1:0]       w_full_nxt;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic             w_rd_bank_nxt;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [LOG2N-1:0] r_rd_cnt;
  logic [LOG2N-1:0] w_rd_cnt_rev;
  logic             r_out_valid;
  logic             r_out_last;
  logic             w_wr_fire;
  logic             w_wr_wrap;
  logic             w_issue;
  logic             w_rd_wrap;

  // Writer
  assign in_ready  = !r_full[r_wr_bank];
  assign w_wr_fire = in_valid & in_ready;
  assign w_wr_wrap = w_wr_fire & (r_wr_cnt == CNT_MAX);

  assign mem_addr0 = {r_wr_bank, r_wr_cnt};
  assign mem_ce0   = w_wr_fire;
  assign mem_we0   = w_wr_fire;
  assign mem_d0    = in_data;

  // Reader: a read is issued when the output register is empty or is being
  // drained this cycle. A stalled beat keeps ce1 low, so q1 (= out_data) holds.
  assign w_issue   = (r_state == R_READ) & (!r_out_valid | out_ready);
  assign w_rd_wrap = w_issue & (r_rd_cnt == CNT_MAX);

  always_comb begin
    w_rd_cnt_rev = '0;
    for (int i = 0; i < LOG2N; i++) begin
      w_rd_cnt_rev[i] = r_rd_cnt[LOG2N-1-i];
    end
  end

  // A bank is set full by the writer's last beat and cleared by the reader's
  // last issue. The two never target the same bank in one cycle: the writer
  // only writes a bank that is not full, and the reader only reads a full bank.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_wrap) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_wrap) w_full_nxt[r_rd_bank] = 1'b0;
  end

  assign w_rd_bank_nxt = r_rd_bank ^ w_rd_wrap;

  // The next state looks at the next full flags. Because of this, a frame that
  // completes on this edge can be read on the next cycle. This also gives
  // back-to-back frames with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    mem_ce1     = 1'b0;
    mem_addr1   = {r_rd_bank, w_rd_cnt_rev};
    case (r_state)
      R_IDLE: begin
        if (w_full_nxt[w_rd_bank_nxt]) w_state_nxt = R_READ;
      end
      R_READ: begin
        mem_ce1 = w_issue;
        if (w_rd_wrap && !w_full_nxt[w_rd_bank_nxt]) w_state_nxt = R_IDLE;
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  assign mem_we1   = 1'b0;
  assign mem_d1    = '0;
  assign out_data  = mem_q1;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= R_IDLE;
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= w_full_nxt;
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_wrap) r_wr_bank <= ~r_wr_bank;
      end
      if (w_issue) begin
        r_rd_cnt    <= r_rd_cnt + 1'b1;
        r_rd_bank   <= w_rd_bank_nxt;
        r_out_valid <= 1'b1;
        r_out_last  <= (r_rd_cnt == CNT_MAX);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

`ifdef BITREV_CTRL_STATS_EN
  logic [15:0] r_frames_out;
  logic [15:0] r_in_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frames_out      <= '0;
      r_in_stall_cycles <= '0;
    end else begin
      if (r_out_valid && out_ready && r_out_last) r_frames_out <= r_frames_out + 16'd1;
      if (in_valid && !in_ready && (r_in_stall_cycles != 16'hFFFF)) begin
        r_in_stall_cycles <= r_in_stall_cycles + 16'd1;
      end
    end
  end

  assign frames_out      = r_frames_out;
  assign in_stall_cycles = r_in_stall_cycles;
`endif

endmodule

// File: tb/tb_bit_reverse_ctrl.sv
// tb/tb_bit_reverse_ctrl.sv - directed self-checking bench for bit_reverse_ctrl (LOG2N=3)
module tb_bit_reverse_ctrl;
  localparam int DW = 32;
  localparam int LG = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [LG:0]   mem_addr0;
  logic          mem_ce0;
  logic          mem_we0;
  logic [DW-1:0] mem_d0;
  logic [LG:0]   mem_addr1;
  logic          mem_ce1;
  logic          mem_we1;
  logic [DW-1:0] mem_d1;
  logic [DW-1:0] mem_q1;
`ifdef BITREV_CTRL_STATS_EN
  logic [15:0]   frames_out;
  logic [15:0]   in_stall_cycles;
`endif

  bit_reverse_ctrl #(.DWIDTH(DW), .LOG2N(LG)) u_dut (
`ifdef BITREV_CTRL_STATS_EN
    .frames_out(frames_out),
    .in_stall_cycles(in_stall_cycles),
`endif
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .mem_addr0(mem_addr0),
    .mem_ce0(mem_ce0),
    .mem_we0(mem_we0),
    .mem_d0(mem_d0),
    .mem_addr1(mem_addr1),
    .mem_ce1(mem_ce1),
    .mem_we1(mem_we1),
    .mem_d1(mem_d1),
    .mem_q1(mem_q1)
  );

  // Synchronous dual-port BRAM with a 1-cycle read; q1 holds while ce1=0.
  logic [DW-1:0] bram [0:15];
  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) bram[mem_addr0] <= mem_d0;
    if (mem_ce1) mem_q1 <= bram[mem_addr1];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int br_tab [8];
  int exp_q [$];
  int bank_at [24];
  int cyc = 0;
  int wr_idx, rd_idx, out_idx, stall_cnt;
  int last_acc_cyc, first_valid_cyc, last_pop_cyc, issue8_cyc, block_acc, rise_cyc;
  bit seen_block, seen_rise, prev_stall;
  logic [DW-1:0] prev_data;
  logic prev_last;

  // Monitor: samples every signal at the negedge, halfway between active edges.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (in_valid && !in_ready) begin
          stall_cnt++;
          check("ce0_when_blocked", mem_ce0, 0);
          if (!seen_block) begin
            seen_block = 1'b1;
            block_acc  = wr_idx;
          end
        end
        if (seen_block && !seen_rise && in_ready) begin
          seen_rise = 1'b1;
          rise_cyc  = cyc;
        end
        if (in_valid && in_ready) begin
          check("wr_ce_we", mem_ce0 & mem_we0, 1);
          check("wr_addr", mem_addr0, wr_idx % 16);
          check("wr_data", mem_d0, in_data);
          wr_idx++;
          last_acc_cyc = cyc;
        end
        if (mem_ce1) begin
          check("rd_addr", mem_addr1, ((rd_idx % 16) / 8) * 8 + br_tab[rd_idx % 8]);
          if (rd_idx < 24) bank_at[rd_idx] = mem_addr1[LG];
          if (rd_idx == 7) issue8_cyc = cyc;
          rd_idx++;
        end
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_data);
          check("hold_last", out_last, prev_last);
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", out_data, e);
            check("out_last", out_last, (out_idx % 8) == 7);
          end
          out_idx++;
          last_pop_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    wr_idx = 0; rd_idx = 0; out_idx = 0; stall_cnt = 0;
    last_acc_cyc = 0; first_valid_cyc = -1; last_pop_cyc = 0;
    issue8_cyc = 0; block_acc = 0; rise_cyc = 0;
    seen_block = 1'b0; seen_rise = 1'b0; prev_stall = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_frames(input int base, input int nframes);
    for (int f = 0; f < nframes; f++)
      for (int i = 0; i < 8; i++)
        exp_q.push_back(base + 8 * f + br_tab[i]);
  endtask

  task automatic send(input int base, input int n);
    bit acc;
    int guard;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = base + k;
      guard    = 0;
      acc      = 1'b0;
      while (!acc && guard < 1000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        check("send_timeout", k, n);
        k = n;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    br_tab = '{0, 4, 2, 6, 1, 5, 3, 7};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ce0", mem_ce0, 0);
    check("rst_ce1", mem_ce1, 0);
    check("rst_we1", mem_we1, 0);
    check("rst_d1", mem_d1, 0);
`ifdef BITREV_CTRL_STATS_EN
    check("rst_frames_out", frames_out, 0);
    check("rst_stalls", in_stall_cycles, 0);
`endif

    // One frame 0..7 -> 0,4,2,6,1,5,3,7 with a 2-cycle latency
    do_reset();
    push_frames(0, 1);
    send(0, 8);
    drain();
    check("s1_latency", first_valid_cyc - last_acc_cyc, 2);
    check("s1_beats", out_idx, 8);
    @(negedge clk);
    check("s1_idle_valid", out_valid, 0);

    // Three back-to-back frames, no bubbles, banks alternate
    do_reset();
    push_frames(0, 3);
    send(0, 24);
    drain();
    check("s2_in_ready_drop", seen_block, 0);
    check("s2_beats", out_idx, 24);
    check("s2_span", last_pop_cyc - first_valid_cyc, 23);
    check("s2_bank_f0", bank_at[0], 0);
    check("s2_bank_f1", bank_at[8], 1);
    check("s2_bank_f2", bank_at[16], 0);

    // Both banks fill under back-pressure, then release
    do_reset();
    out_ready = 1'b0;
    push_frames(100, 3);
    fork
      send(100, 24);
      begin
        int g = 0;
        while (!seen_block && g < 200) begin
          @(posedge clk);
          g++;
        end
        check("s3_blocked", seen_block, 1);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("s3_block_after", block_acc, 16);
    check("s3_rise_delay", rise_cyc - issue8_cyc, 1);
    check("s3_beats", out_idx, 24);
`ifdef BITREV_CTRL_STATS_EN
    check("s3_frames_out", frames_out, 3);
    check("s3_stall_cycles", in_stall_cycles, stall_cnt);
`endif

    // Random out_ready toggling against the bitrev sequence
    do_reset();
    push_frames(200, 2);
    fork
      send(200, 16);
      begin
        for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    check("s4_beats", out_idx, 16);

    // Reset with one frame pending and a partial frame in progress
    do_reset();
    out_ready = 1'b0;
    send(50, 8);
    send(60, 5);
    do_reset();
    @(negedge clk);
    check("s5_out_valid", out_valid, 0);
    check("s5_out_last", out_last, 0);
    check("s5_in_ready", in_ready, 1);
    check("s5_ce1", mem_ce1, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_frames(8, 1);
    send(8, 8);
    drain();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("s5_beats", out_idx, 8);
    check("s5_idle_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
